gpio_event_blinker: RTL and testbench

- Output-side counterpart to the pushbutton input path. It turns single-cycle event pulses from the design into human-visible blinks on a GPIO/LED pin.
- Each accepted event produces exactly one ON phase followed by one OFF gap. Events that arrive while a blink is in progress are queued in a saturating counter and replayed back-to-back.
- Sits between internal event sources (debounced buttons, UART rx/tx strobes) and the board LED pins. Runs on the single system clock with an internal tick divider.

---
 rtl/gpio_event_blinker.sv | 119 +++++++++++
 tb/tb_gpio_event_blinker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_event_blinker.sv
// Purpose: turns single-cycle event strobes into visible LED blinks (one ON phase + one OFF gap each).
// Latency: evt_pulse in cycle t lights led_out in cycle t+1 when idle; queued events replay back-to-back.
// Backpressure: none upstream; up to 2^CNT_W-1 events are queued, further ones are dropped and flagged in overflow.
module gpio_event_blinker #(
    parameter int TICK_DIV    = 50000, // src_clk cycles per internal tick
    parameter int ON_TICKS    = 100,   // ticks per ON phase
    parameter int OFF_TICKS   = 100,   // ticks per OFF gap
    parameter int CNT_W       = 4,     // pending-event counter width
    parameter int ACTIVE_HIGH = 1      // 1: led_out=1 is lit, 0: led_out=0 is lit
) (
    input  logic             src_clk,   // system clock, rising edge
    input  logic             rst,       // synchronous active-high reset
    input  logic             evt_pulse, // one event per high cycle
    input  logic             clr_ovf,   // clears the sticky overflow flag
    output logic             led_out,   // registered LED drive
    output logic             busy,      // high whenever not idle
    output logic [CNT_W-1:0] pending,   // queued events not yet started
    output logic             overflow   // sticky: an event was dropped at saturation
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TK_W   = (TK_MAX > 1) ? $clog2(TK_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TK_W-1:0]  ON_LAST  = TK_W'(ON_TICKS - 1);
    localparam logic [TK_W-1:0]  OFF_LAST = TK_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic             LED_LIT  = (ACTIVE_HIGH != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [TK_W-1:0]  tick_cnt;
    logic             tick;
    logic             on_done;
    logic             off_done;
    logic             q_take;
    logic             q_push;
    logic             evt_drop;
    logic [CNT_W-1:0] pending_nxt;

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        on_done  = (state == ST_ON)  && tick && (tick_cnt == ON_LAST);
        off_done = (state == ST_OFF) && tick && (tick_cnt == OFF_LAST);

        // Restart from the queue only when something is actually queued.
        q_take = off_done && (pending != '0);

        // While blinking, every event is queued, except the one that arrives at
        // the end of a gap with an empty queue: that one starts the next blink
        // directly and never touches the counter.
        q_push = (state != ST_IDLE) && evt_pulse && !(off_done && (pending == '0));

        // A simultaneous take frees a slot, so saturation only drops without one.
        evt_drop = q_push && !q_take && (pending == PEND_MAX);

        state_nxt = state;
        case (state)
            ST_IDLE: if (evt_pulse) state_nxt = ST_ON;
            ST_ON:   if (on_done) state_nxt = ST_OFF;
            ST_OFF:  if (off_done) state_nxt = (q_take || evt_pulse) ? ST_ON : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        pending_nxt = pending;
        if (q_push && !q_take && !evt_drop) begin
            pending_nxt = pending + CNT_W'(1);
        end else if (q_take && !q_push) begin
            pending_nxt = pending - CNT_W'(1);
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led_out  <= ~LED_LIT;
            busy     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;

            // Set wins over clear when both happen in one cycle.
            if (evt_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            // Timing restarts from zero on every state change so each phase
            // has an exact length regardless of where the divider was.
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + TK_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // Outputs follow the next state so they line up with the state register.
            led_out <= (state_nxt == ST_ON) ? LED_LIT : ~LED_LIT;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gpio_event_blinker.sv
// Purpose: scoreboard bench for gpio_event_blinker using directed event timelines.
// Latency: expected output records carry the absolute cycle at which each output change must appear.
// Backpressure: none; the monitor pops a record on every output change or scheduled sample.
module tb_gpio_event_blinker;

    logic       src_clk;
    logic       rst;
    logic       evt_pulse;
    logic       clr_ovf;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    gpio_event_blinker #(
        .TICK_DIV    (4),
        .ON_TICKS    (2),
        .OFF_TICKS   (1),
        .CNT_W       (2),
        .ACTIVE_HIGH (1)
    ) dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .evt_pulse (evt_pulse),
        .clr_ovf   (clr_ovf),
        .led_out   (led_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    // Expected output snapshot {led_out, busy, pending, overflow} at a cycle.
    typedef struct packed {
        int         cyc;
        logic [4:0] val;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   mon_en  = 0;
    bit   primed  = 0;
    bit   done    = 0;
    bit   drained = 0;
    logic [4:0] cur;
    logic [4:0] prev;

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    always @(posedge src_clk) cyc <= cyc + 1;

    // Monitor: every output change, and every scheduled sample point, pops one record.
    always @(negedge src_clk) begin
        exp_t  r;
        string t;
        if (mon_en && !drained) begin
            cur = {led_out, busy, pending, overflow};
            if (!primed) begin
                prev   = cur;
                primed = 1;
            end
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                r = expq.pop_front();
                t = tagq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: no matching output by cycle %0d, required {led,busy,pend,ovf}=%b at cycle %0d",
                         t, cyc, r.val, r.cyc);
            end
            if ((cur != prev) || (expq.size() > 0 && expq[0].cyc == cyc)) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: output changed to %b at cycle %0d with nothing expected", cur, cyc);
                end else begin
                    r = expq.pop_front();
                    t = tagq.pop_front();
                    if (r.cyc != cyc || r.val != cur) begin
                        errors++;
                        $display("FAIL %s: got {led,busy,pend,ovf}=%b at cycle %0d, required %b at cycle %0d",
                                 t, cur, cyc, r.val, r.cyc);
                    end
                end
            end
            prev = cur;
            if (done) begin
                while (expq.size() > 0) begin
                    r = expq.pop_front();
                    t = tagq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s: never observed, required %b at cycle %0d", t, r.val, r.cyc);
                end
                drained = 1;
            end
        end
    end

    task automatic exp_at(input int c, input logic l, input logic b, input logic [1:0] p,
                          input logic o, input string tag);
        exp_t r;
        r.cyc = c;
        r.val = {l, b, p, o};
        expq.push_back(r);
        tagq.push_back(tag);
    endtask

    // Returns #1 after the posedge that starts cycle c; inputs driven then apply to cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge src_clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        evt_pulse = 1'b0;
        clr_ovf   = 1'b0;
        goto(2);
        rst = 1'b0;

        // Reset state, stable for 100 cycles.
        exp_at(2,   0, 0, 2'd0, 0, "reset_state");
        exp_at(50,  0, 0, 2'd0, 0, "reset_hold50");
        exp_at(102, 0, 0, 2'd0, 0, "reset_hold100");
        mon_en = 1;

        // Single event at T+10.
        goto(110);
        exp_at(121, 1, 1, 2'd0, 0, "single_on");
        exp_at(129, 0, 1, 2'd0, 0, "single_off");
        exp_at(133, 0, 0, 2'd0, 0, "single_idle");
        goto(120); evt_pulse = 1'b1;
        goto(121); evt_pulse = 1'b0;

        // Three events, two queued.
        goto(150);
        exp_at(161, 1, 1, 2'd0, 0, "three_on1");
        exp_at(163, 1, 1, 2'd1, 0, "three_q1");
        exp_at(165, 1, 1, 2'd2, 0, "three_q2");
        exp_at(169, 0, 1, 2'd2, 0, "three_off1");
        exp_at(173, 1, 1, 2'd1, 0, "three_on2");
        exp_at(181, 0, 1, 2'd1, 0, "three_off2");
        exp_at(185, 1, 1, 2'd0, 0, "three_on3");
        exp_at(193, 0, 1, 2'd0, 0, "three_off3");
        exp_at(197, 0, 0, 2'd0, 0, "three_idle");
        goto(160); evt_pulse = 1'b1;
        goto(161); evt_pulse = 1'b0;
        goto(162); evt_pulse = 1'b1;
        goto(163); evt_pulse = 1'b0;
        goto(164); evt_pulse = 1'b1;
        goto(165); evt_pulse = 1'b0;

        // Six back-to-back events: saturation, overflow (clr_ovf held during the
        // drops must lose), four blinks, then an explicit clear.
        goto(210);
        exp_at(221, 1, 1, 2'd0, 0, "sat_on1");
        exp_at(222, 1, 1, 2'd1, 0, "sat_q1");
        exp_at(223, 1, 1, 2'd2, 0, "sat_q2");
        exp_at(224, 1, 1, 2'd3, 0, "sat_q3");
        exp_at(225, 1, 1, 2'd3, 1, "sat_ovf");
        exp_at(229, 0, 1, 2'd3, 1, "sat_off1");
        exp_at(233, 1, 1, 2'd2, 1, "sat_on2");
        exp_at(241, 0, 1, 2'd2, 1, "sat_off2");
        exp_at(245, 1, 1, 2'd1, 1, "sat_on3");
        exp_at(253, 0, 1, 2'd1, 1, "sat_off3");
        exp_at(257, 1, 1, 2'd0, 1, "sat_on4");
        exp_at(265, 0, 1, 2'd0, 1, "sat_off4");
        exp_at(269, 0, 0, 2'd0, 1, "sat_idle");
        exp_at(276, 0, 0, 2'd0, 0, "ovf_clear");
        goto(220); evt_pulse = 1'b1;
        goto(224); clr_ovf = 1'b1;
        goto(226); evt_pulse = 1'b0; clr_ovf = 1'b0;
        goto(275); clr_ovf = 1'b1;
        goto(276); clr_ovf = 1'b0;

        // Event in the last OFF cycle with an empty queue: direct restart.
        goto(290);
        exp_at(301, 1, 1, 2'd0, 0, "lastoff0_on1");
        exp_at(309, 0, 1, 2'd0, 0, "lastoff0_off1");
        exp_at(312, 0, 1, 2'd0, 0, "lastoff0_gapend");
        exp_at(313, 1, 1, 2'd0, 0, "lastoff0_on2");
        exp_at(321, 0, 1, 2'd0, 0, "lastoff0_off2");
        exp_at(325, 0, 0, 2'd0, 0, "lastoff0_idle");
        goto(300); evt_pulse = 1'b1;
        goto(301); evt_pulse = 1'b0;
        goto(312); evt_pulse = 1'b1;
        goto(313); evt_pulse = 1'b0;

        // Same with one event queued: take and push cancel, pending stays 1.
        goto(340);
        exp_at(351, 1, 1, 2'd0, 0, "lastoff1_on1");
        exp_at(353, 1, 1, 2'd1, 0, "lastoff1_q1");
        exp_at(359, 0, 1, 2'd1, 0, "lastoff1_off1");
        exp_at(363, 1, 1, 2'd1, 0, "lastoff1_on2");
        exp_at(371, 0, 1, 2'd1, 0, "lastoff1_off2");
        exp_at(375, 1, 1, 2'd0, 0, "lastoff1_on3");
        exp_at(383, 0, 1, 2'd0, 0, "lastoff1_off3");
        exp_at(387, 0, 0, 2'd0, 0, "lastoff1_idle");
        goto(350); evt_pulse = 1'b1;
        goto(351); evt_pulse = 1'b0;
        goto(352); evt_pulse = 1'b1;
        goto(353); evt_pulse = 1'b0;
        goto(362); evt_pulse = 1'b1;
        goto(363); evt_pulse = 1'b0;

        // Reset mid-ON together with an event: abort, nothing follows.
        goto(400);
        exp_at(411, 1, 1, 2'd0, 0, "rst_on");
        exp_at(413, 1, 1, 2'd1, 0, "rst_q1");
        exp_at(415, 0, 0, 2'd0, 0, "rst_abort");
        exp_at(430, 0, 0, 2'd0, 0, "rst_noblink");
        goto(410); evt_pulse = 1'b1;
        goto(411); evt_pulse = 1'b0;
        goto(412); evt_pulse = 1'b1;
        goto(413); evt_pulse = 1'b0;
        goto(414); evt_pulse = 1'b1; rst = 1'b1;
        goto(415); evt_pulse = 1'b0; rst = 1'b0;

        goto(450);
        done = 1;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(posedge src_clk);
        end
        if (!drained) begin
            $display("FAIL drain: monitor did not finish draining the scoreboard");
            $fatal(1, "drain");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
